fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_pkg.sv | 48 ++++
 rtl/fifo_rd_ctrl_sync.sv | 24 ++
 rtl/fifo_rd_ctrl.sv | 85 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry, read-side flag bundle,
// and Gray/binary pointer conversion used by both clock domains.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int FIFO_AE_THRESH  = 2;

  // Conversions work on a 32-bit container so any pointer width
  // up to 32 bits can use them after zero-extension and a slice.
  localparam int PTR_MAX = 32;

  typedef logic [PTR_MAX-1:0] ptr_max_t;

  typedef struct packed {
    logic empty;
    logic almost_empty;
    logic valid;
    logic underflow;
  } rd_flags_t;

  localparam rd_flags_t RD_FLAGS_RST = '{
    empty:        1'b1,
    almost_empty: 1'b1,
    valid:        1'b0,
    underflow:    1'b0
  };

  function automatic ptr_max_t bin2gray(
    input ptr_max_t b
  );
    return b ^ (b >> 1);
  endfunction

  // Zero-extended Gray codes convert correctly:
  // leading zeros stay zero through the prefix XOR.
  function automatic ptr_max_t gray2bin(
    input ptr_max_t g
  );
    ptr_max_t b;
    b = '0;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_sync.sv
// Two-flop synchronizer for a multi-bit Gray-coded pointer.
// Ports: clk, rst (async, active-high), d (async input), q (synchronized).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] wq1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wq1 <= '0;
      q   <= '0;
    end else begin
      wq1 <= d;
      q   <= wq1;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: read pointer, memory read port
// control, Gray pointer export and empty/almost-empty/occupancy status.
// Ports: rd_clk, rd_rst (async, active-high), rd_req (pop request),
//   wr_ptr_gray (async write pointer), rd_en/rd_addr (memory read port),
//   rd_ptr_gray (to write domain), rd_valid (read data valid),
//   empty, almost_empty, rd_count (occupancy), rd_underflow (reject).
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AE_THRESH  = FIFO_AE_THRESH
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  rd_underflow
);

  localparam int PW = ADDR_WIDTH + 1;

  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0] wq2;
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] rd_bin_next;
  logic [PW-1:0] rd_gray_next;
  logic [PW-1:0] ae_level;

  rd_flags_t flags;

  sync_2ff #(
    .WIDTH (PW)
  ) u_wptr_sync (
    .clk (rd_clk),
    .rst (rd_rst),
    .d   (wr_ptr_gray),
    .q   (wq2)
  );

  assign wr_bin = PW'(gray2bin(ptr_max_t'(wq2)));

  // Reset gating keeps the port quiet while rd_rst is high, even in the
  // same delta the async clear of the flag register takes effect.
  assign rd_en = rd_req & ~flags.empty & ~rd_rst;

  assign rd_bin_next  = rd_bin + PW'(rd_en);
  assign rd_gray_next = PW'(bin2gray(ptr_max_t'(rd_bin_next)));

  // Occupancy after this cycle's pop, against the write pointer already
  // synchronized; a wq2 arriving on the same edge is seen next cycle.
  assign ae_level = wr_bin - rd_bin_next;

  assign rd_addr  = rd_bin[ADDR_WIDTH-1:0];
  assign rd_count = rd_rst ? '0 : wr_bin - rd_bin;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_bin      <= '0;
      rd_ptr_gray <= '0;
      flags       <= RD_FLAGS_RST;
    end else begin
      rd_bin             <= rd_bin_next;
      rd_ptr_gray        <= rd_gray_next;
      flags.empty        <= (rd_gray_next == wq2);
      flags.almost_empty <= (ae_level <= AE_LVL);
      flags.valid        <= rd_en;
      flags.underflow    <= rd_req & flags.empty;
    end
  end

  assign empty        = flags.empty;
  assign almost_empty = flags.almost_empty;
  assign rd_valid     = flags.valid;
  assign rd_underflow = flags.underflow;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl (ADDR_WIDTH=4, AE_THRESH=2):
// vector table, directed corner sequences and a randomized model check.
module tb_fifo_rd_ctrl;

  logic       rd_clk = 1'b0;
  logic       rd_rst;
  logic       rd_req;
  logic [4:0] wr_ptr_gray;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [4:0] rd_ptr_gray;
  logic       rd_valid;
  logic       empty;
  logic       almost_empty;
  logic [4:0] rd_count;
  logic       rd_underflow;

  int checks   = 0;
  int failures = 0;

  fifo_rd_ctrl #(
    .ADDR_WIDTH (4),
    .AE_THRESH  (2)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .rd_req       (rd_req),
    .wr_ptr_gray  (wr_ptr_gray),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_ptr_gray  (rd_ptr_gray),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_count     (rd_count),
    .rd_underflow (rd_underflow)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct {
    logic       req;
    logic [4:0] wg;
    logic       en;
    logic [3:0] addr;
    logic       vld;
    logic       emp;
    logic       ae;
    logic       uf;
    logic [4:0] cnt;
    logic [4:0] pg;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic do_reset();
    rd_rst      = 1'b1;
    rd_req      = 1'b0;
    wr_ptr_gray = '0;
    repeat (2) tick();
    rd_rst = 1'b0;
  endtask

  // Reference model state: plain pointer arithmetic modulo 32.
  int  m_w;
  int  m_rd;
  int  m_vis1;
  int  m_vis2;
  bit  m_emp;
  bit  m_ae;
  bit  m_vld;
  bit  m_uf;
  int  m_pg;

  initial begin
    rd_rst      = 1'b1;
    rd_req      = 1'b0;
    wr_ptr_gray = '0;

    // Reset values
    @(negedge rd_clk);
    chk("rst_empty", empty, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_pg", rd_ptr_gray, 0);
    chk("rst_cnt", rd_count, 0);
    chk("rst_en", rd_en, 0);
    chk("rst_vld", rd_valid, 0);
    chk("rst_uf", rd_underflow, 0);
    @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;

    // Visibility latency, drain and underflow
    tbl[0] = '{0, 5'b00010, 0, 0, 0, 1, 1, 0, 0, 5'b00000};
    tbl[1] = '{0, 5'b00010, 0, 0, 0, 1, 1, 0, 0, 5'b00000};
    tbl[2] = '{0, 5'b00010, 0, 0, 0, 1, 1, 0, 3, 5'b00000};
    tbl[3] = '{1, 5'b00010, 1, 0, 0, 0, 0, 0, 3, 5'b00000};
    tbl[4] = '{1, 5'b00010, 1, 1, 1, 0, 1, 0, 2, 5'b00001};
    tbl[5] = '{1, 5'b00010, 1, 2, 1, 0, 1, 0, 1, 5'b00011};
    tbl[6] = '{1, 5'b00010, 0, 3, 1, 1, 1, 0, 0, 5'b00010};
    tbl[7] = '{0, 5'b00010, 0, 3, 0, 1, 1, 1, 0, 5'b00010};
    tbl[8] = '{0, 5'b00010, 0, 3, 0, 1, 1, 0, 0, 5'b00010};

    for (int i = 0; i < 9; i++) begin
      rd_req      = tbl[i].req;
      wr_ptr_gray = tbl[i].wg;
      @(negedge rd_clk);
      chk($sformatf("v%0d_en", i), rd_en, tbl[i].en);
      chk($sformatf("v%0d_addr", i), rd_addr, tbl[i].addr);
      chk($sformatf("v%0d_vld", i), rd_valid, tbl[i].vld);
      chk($sformatf("v%0d_emp", i), empty, tbl[i].emp);
      chk($sformatf("v%0d_ae", i), almost_empty, tbl[i].ae);
      chk($sformatf("v%0d_uf", i), rd_underflow, tbl[i].uf);
      chk($sformatf("v%0d_cnt", i), rd_count, tbl[i].cnt);
      chk($sformatf("v%0d_pg", i), rd_ptr_gray, tbl[i].pg);
      tick();
    end

    // Pointer wrap: 18 entries from a fresh reset
    do_reset();
    wr_ptr_gray = 5'b11011;
    repeat (3) tick();
    for (int i = 0; i < 18; i++) begin
      rd_req = 1'b1;
      @(negedge rd_clk);
      chk($sformatf("wrap%0d_en", i), rd_en, 1);
      chk($sformatf("wrap%0d_addr", i), rd_addr, i % 16);
      tick();
      if (i == 14) chk("wrap_pg4_pre", rd_ptr_gray[4], 0);
      if (i == 15) chk("wrap_pg4_set", rd_ptr_gray[4], 1);
    end
    rd_req = 1'b0;
    chk("wrap_empty", empty, 1);
    chk("wrap_addr_end", rd_addr, 2);
    chk("wrap_pg_end", rd_ptr_gray, 5'b11011);

    // Full occupancy
    do_reset();
    wr_ptr_gray = 5'b11000;
    repeat (3) tick();
    @(negedge rd_clk);
    chk("full_cnt", rd_count, 16);
    chk("full_empty", empty, 0);
    chk("full_ae", almost_empty, 0);

    // Reset in the middle of a burst
    tick();
    rd_req = 1'b1;
    repeat (2) tick();
    #2;
    rd_rst = 1'b1;
    #1;
    chk("mid_empty", empty, 1);
    chk("mid_en", rd_en, 0);
    chk("mid_cnt", rd_count, 0);
    chk("mid_pg", rd_ptr_gray, 0);
    chk("mid_vld", rd_valid, 0);
    tick();
    rd_req = 1'b0;
    rd_rst = 1'b0;
    @(negedge rd_clk);
    chk("resume_uf", rd_underflow, 0);
    chk("resume_vld", rd_valid, 0);
    chk("resume_addr", rd_addr, 0);
    tick();
    chk("resume_uf2", rd_underflow, 0);
    chk("resume_vld2", rd_valid, 0);

    // Randomized traffic against the reference model
    do_reset();
    m_w    = 0;
    m_rd   = 0;
    m_vis1 = 0;
    m_vis2 = 0;
    m_emp  = 1;
    m_ae   = 1;
    m_vld  = 0;
    m_uf   = 0;
    m_pg   = 0;
    for (int i = 0; i < 800; i++) begin
      int wprob;
      int occ;
      int nxt;
      bit en;
      bit req;
      wprob = ((i / 100) % 2 == 0) ? 3 : 1;
      if (($urandom % 4) < wprob && ((m_w - m_rd) & 31) < 16)
        m_w = (m_w + 1) & 31;
      req = (($urandom % 4) < (((i / 100) % 2 == 0) ? 1 : 3));
      rd_req      = req;
      wr_ptr_gray = gray5(m_w);
      @(negedge rd_clk);
      occ = (m_vis2 - m_rd) & 31;
      en  = req && !m_emp;
      chk("rnd_en", rd_en, en);
      chk("rnd_addr", rd_addr, m_rd & 15);
      chk("rnd_cnt", rd_count, occ);
      chk("rnd_emp", empty, m_emp);
      chk("rnd_ae", almost_empty, m_ae);
      chk("rnd_vld", rd_valid, m_vld);
      chk("rnd_uf", rd_underflow, m_uf);
      chk("rnd_pg", rd_ptr_gray, m_pg);
      @(posedge rd_clk);
      nxt    = (m_rd + (en ? 1 : 0)) & 31;
      m_uf   = req && m_emp;
      m_vld  = en;
      m_emp  = (((m_vis2 - nxt) & 31) == 0);
      m_ae   = (((m_vis2 - nxt) & 31) <= 2);
      m_pg   = gray5(nxt);
      m_rd   = nxt;
      m_vis2 = m_vis1;
      m_vis1 = m_w;
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
